// File: rtl/mod_16_counter.sv
// Free-running modulo-N binary counter with a combinational terminal-count flag
// and a registered one-cycle wrap pulse. Counts up or down, selected by parameter.
module mod_16_counter #(
   parameter int WIDTH      = 4,
   parameter int MODULUS    = 16,
   parameter bit COUNT_DOWN = 1'b0
) (
   input  logic             CLK,
   input  logic             RESET,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             WRAP
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
   // Terminal value is the last count before the wrap: top of range going up, zero going down.
   localparam logic [WIDTH-1:0] TERM = COUNT_DOWN ? '0 : LAST;

   logic             at_term;
   logic [WIDTH-1:0] q_next;

   assign at_term = (Q == TERM);

   // Gating with RESET keeps TC low while reset holds Q at zero in down mode.
   assign TC = at_term && RESET;

   always_comb begin
      q_next = Q;
      if (COUNT_DOWN) begin
         q_next = at_term ? LAST : Q - 1'b1;
      end else begin
         q_next = at_term ? '0 : Q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Q    <= '0;
         WRAP <= 1'b0;
      end else begin
         Q    <= q_next;
         WRAP <= at_term;
      end
   end

endmodule

// File: tb/tb_mod_16_counter.sv
// Self-checking bench for mod_16_counter: default up-counter plus a MODULUS=10
// down-counting instance, driven by directed vectors and a few timed sequences.
module tb_mod_16_counter;

   typedef struct {
      logic       rst;
      logic [3:0] q;
      logic       tc;
      logic       wrap;
   } vec_t;

   logic       CLK;
   logic       rst_up, rst_dn;
   logic [3:0] up_q, dn_q;
   logic       up_tc, dn_tc, up_wrap, dn_wrap;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t up_vec [34];
   vec_t dn_vec [13];

   mod_16_counter dut_up (
      .CLK   (CLK),
      .RESET (rst_up),
      .Q     (up_q),
      .TC    (up_tc),
      .WRAP  (up_wrap)
   );

   mod_16_counter #(.WIDTH(4), .MODULUS(10), .COUNT_DOWN(1'b1)) dut_dn (
      .CLK   (CLK),
      .RESET (rst_dn),
      .Q     (dn_q),
      .TC    (dn_tc),
      .WRAP  (dn_wrap)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int  wraps;
      bit  found;

      // Up counter: two full periods after release from reset.
      for (int i = 0; i < 34; i++) begin
         up_vec[i].rst  = 1'b1;
         up_vec[i].q    = 4'((i + 1) % 16);
         up_vec[i].tc   = (up_vec[i].q == 4'd15);
         up_vec[i].wrap = (up_vec[i].q == 4'd0);
      end

      // Down counter, MODULUS=10: one held-reset edge, then 9..0 and wrap back to 9.
      dn_vec[0]  = '{1'b0, 4'd0, 1'b0, 1'b0};
      dn_vec[1]  = '{1'b1, 4'd9, 1'b0, 1'b1};
      dn_vec[2]  = '{1'b1, 4'd8, 1'b0, 1'b0};
      dn_vec[3]  = '{1'b1, 4'd7, 1'b0, 1'b0};
      dn_vec[4]  = '{1'b1, 4'd6, 1'b0, 1'b0};
      dn_vec[5]  = '{1'b1, 4'd5, 1'b0, 1'b0};
      dn_vec[6]  = '{1'b1, 4'd4, 1'b0, 1'b0};
      dn_vec[7]  = '{1'b1, 4'd3, 1'b0, 1'b0};
      dn_vec[8]  = '{1'b1, 4'd2, 1'b0, 1'b0};
      dn_vec[9]  = '{1'b1, 4'd1, 1'b0, 1'b0};
      dn_vec[10] = '{1'b1, 4'd0, 1'b1, 1'b0};
      dn_vec[11] = '{1'b1, 4'd9, 1'b0, 1'b1};
      dn_vec[12] = '{1'b1, 4'd8, 1'b0, 1'b0};

      // Power-up reset, no clock edge yet.
      rst_up = 1'b0;
      rst_dn = 1'b0;
      #3;
      check("up_reset_q",    up_q,    4'd0);
      check("up_reset_tc",   up_tc,   1'b0);
      check("up_reset_wrap", up_wrap, 1'b0);
      check("dn_reset_q",    dn_q,    4'd0);
      check("dn_reset_tc",   dn_tc,   1'b0);
      check("dn_reset_wrap", dn_wrap, 1'b0);

      // Release at 6 ns; edges at 15, 25, 35 ns.
      #3 rst_up = 1'b1;
      tick(); check("up_first_q",  up_q, 4'd1);
      tick(); check("up_second_q", up_q, 4'd2);
      tick(); check("up_third_q",  up_q, 4'd3);
      check("up_third_tc", up_tc, 1'b0);

      // Asynchronous reset at 41 ns, between edges.
      #5 rst_up = 1'b0;
      #1;
      check("up_async_q",    up_q,    4'd0);
      check("up_async_tc",   up_tc,   1'b0);
      check("up_async_wrap", up_wrap, 1'b0);
      #9 rst_up = 1'b1;

      // Full wrap and long run.
      wraps = 0;
      for (int i = 0; i < 34; i++) begin
         rst_up = up_vec[i].rst;
         tick();
         check($sformatf("up_vec%0d_q", i),    up_q,    up_vec[i].q);
         check($sformatf("up_vec%0d_tc", i),   up_tc,   up_vec[i].tc);
         check($sformatf("up_vec%0d_wrap", i), up_wrap, up_vec[i].wrap);
         if (up_wrap === 1'b1) wraps++;
      end
      check("up_wrap_count", wraps, 2);

      #2 rst_up = 1'b0;
      #1;
      check("up_final_reset_q", up_q, 4'd0);

      // Reset asserted while the wrap pulse is high.
      @(negedge CLK);
      rst_up = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (up_wrap === 1'b1) found = 1'b1;
      end
      check("up_wrap_seen", found, 1'b1);
      check("up_wrap_at_q0", up_q, 4'd0);
      #2 rst_up = 1'b0;
      #1;
      check("up_pulse_reset_wrap", up_wrap, 1'b0);
      check("up_pulse_reset_q",    up_q,    4'd0);

      // Down counter: still in reset, TC forced low.
      check("dn_held_q",  dn_q,  4'd0);
      check("dn_held_tc", dn_tc, 1'b0);
      @(negedge CLK);
      rst_dn = 1'b1;
      #1;
      check("dn_release_tc", dn_tc, 1'b1);
      rst_dn = 1'b0;
      #1;
      check("dn_reassert_tc", dn_tc, 1'b0);

      for (int i = 0; i < 13; i++) begin
         rst_dn = dn_vec[i].rst;
         tick();
         check($sformatf("dn_vec%0d_q", i),    dn_q,    dn_vec[i].q);
         check($sformatf("dn_vec%0d_tc", i),   dn_tc,   dn_vec[i].tc);
         check($sformatf("dn_vec%0d_wrap", i), dn_wrap, dn_vec[i].wrap);
         check($sformatf("dn_vec%0d_range", i), (dn_q <= 4'd9), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
